// File: rtl/sram_like_arbiter_if.sv
// Bus bundle between the two sram-like requesters, the arbiter and the shared memory port.
interface sram_like_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  // Instruction requester
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok;
  logic [DW-1:0] inst_rdata;
  logic          inst_data_ok;
  logic          inst_cancel;
  logic          inst_pending;

  // Data requester
  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic [DW-1:0] data_rdata;
  logic          data_data_ok;

  // Shared downstream memory port
  logic          mem_req;
  logic          mem_wr;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_addr_ok;
  logic [DW-1:0] mem_rdata;
  logic          mem_data_ok;

  // Arbiter side
  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    output inst_addr_ok, inst_rdata, inst_data_ok, inst_pending,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_rdata, data_data_ok,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_rdata, mem_data_ok
  );

  // Requester / memory-model side
  modport master (
    output inst_req, inst_addr, inst_cancel,
    input  inst_addr_ok, inst_rdata, inst_data_ok, inst_pending,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_rdata, data_data_ok,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    output mem_addr_ok, mem_rdata, mem_data_ok
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between the instruction and data requesters.
// Requests pass straight through in the cycle they win; an in-order ID FIFO
// steers each downstream data_ok back to the requester that issued it.
module sram_like_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic               clk,
  input  logic               reset,
  sram_like_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  // Grant lock and starvation state
  logic             r_lock_v;
  owner_e           r_lock_own;
  logic [STV_W-1:0] r_starve;

  // ID FIFO storage
  owner_e                   r_own [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] r_disc;
  logic [PTR_W-1:0]         r_rd;
  logic [PTR_W-1:0]         r_wr;
  logic [CNT_W-1:0]         r_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_starve_pri;
  logic             w_grant_d;
  logic             w_grant_i;
  owner_e           w_winner;
  logic             w_mem_req;
  logic             w_accept;
  logic             w_pop;
  owner_e           w_head_own;
  logic             w_head_disc;
  logic [PTR_W-1:0] w_off;
  logic             w_inst_pending;

  assign w_full       = (r_cnt == CNT_W'(MAX_OUTSTANDING));
  assign w_empty      = (r_cnt == '0);
  assign w_starve_pri = (r_starve >= STV_W'(STARVE_LIMIT)) & bus.inst_req;

  // Pick the winner: a held lock pins the owner, otherwise data first unless inst is starved
  always_comb begin
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    if (r_lock_v) begin
      if (r_lock_own == OWN_DATA) w_grant_d = bus.data_req;
      else                        w_grant_i = bus.inst_req;
    end else if (bus.data_req && !w_starve_pri) begin
      w_grant_d = 1'b1;
    end else begin
      w_grant_i = bus.inst_req;
    end
  end

  assign w_winner  = w_grant_d ? OWN_DATA : OWN_INST;
  assign w_mem_req = (w_grant_d | w_grant_i) & ~w_full & ~reset;
  assign w_accept  = w_mem_req & bus.mem_addr_ok;

  // Downstream request fields follow the granted requester; inst is always a word read
  always_comb begin
    bus.mem_wr    = 1'b0;
    bus.mem_size  = 2'b10;
    bus.mem_addr  = bus.inst_addr;
    bus.mem_wdata = '0;
    if (w_grant_d) begin
      bus.mem_wr    = bus.data_wr;
      bus.mem_size  = bus.data_size;
      bus.mem_addr  = bus.data_addr;
      bus.mem_wdata = bus.data_wdata;
    end
  end

  assign bus.mem_req      = w_mem_req;
  assign bus.inst_addr_ok = w_grant_i & w_accept;
  assign bus.data_addr_ok = w_grant_d & w_accept;

  // Response routing from the FIFO head; a cancel in the pop cycle already silences it
  assign w_pop       = bus.mem_data_ok & ~w_empty & ~reset;
  assign w_head_own  = r_own[r_rd];
  assign w_head_disc = r_disc[r_rd];

  assign bus.inst_data_ok = w_pop & (w_head_own == OWN_INST) & ~w_head_disc & ~bus.inst_cancel;
  assign bus.data_data_ok = w_pop & (w_head_own == OWN_DATA);
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;

  // Live inst entries: slot i is valid when its distance from the head is below the count
  always_comb begin
    w_inst_pending = 1'b0;
    w_off          = '0;
    for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
      w_off = PTR_W'(i) - r_rd;
      if ((CNT_W'(w_off) < r_cnt) && (r_own[i] == OWN_INST) && !r_disc[i]) begin
        w_inst_pending = 1'b1;
      end
    end
  end

  assign bus.inst_pending = w_inst_pending;

  // Hold the grant while the downstream stalls so the presented request stays stable
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock_v   <= 1'b0;
      r_lock_own <= OWN_INST;
    end else if (w_accept) begin
      r_lock_v   <= 1'b0;
    end else if (w_mem_req) begin
      r_lock_v   <= 1'b1;
      r_lock_own <= w_winner;
    end
  end

  // Count inst arbitrations lost to completed data handshakes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (bus.inst_addr_ok) begin
      r_starve <= '0;
    end else if (w_accept && w_grant_d && bus.inst_req && (r_starve < STV_W'(STARVE_LIMIT))) begin
      r_starve <= r_starve + STV_W'(1);
    end
  end

  // ID FIFO: cancel marks inst entries first so a same-cycle push stays live
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_disc <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) r_own[i] <= OWN_INST;
    end else begin
      if (bus.inst_cancel) begin
        for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
          if (r_own[i] == OWN_INST) r_disc[i] <= 1'b1;
        end
      end
      if (w_accept) begin
        r_own[r_wr]  <= w_winner;
        r_disc[r_wr] <= 1'b0;
        r_wr         <= r_wr + PTR_W'(1);
      end
      if (w_pop) r_rd <= r_rd + PTR_W'(1);
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // A response with nothing outstanding breaks the downstream protocol
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset) !(bus.mem_data_ok && w_empty));

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_sram_like_arbiter;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 8;

  logic clk;
  logic reset;
  sram_like_arbiter_if bus_if ();

  sram_like_arbiter #(.MAX_OUTSTANDING(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: outstanding responses in issue order, lock owner, starvation count
  typedef struct {bit own_d; bit disc;} ent_t;
  ent_t mq[$];
  bit   m_lock_v;
  bit   m_lock_d;
  int   m_starve;

  int win;  // 0 none, 1 inst, 2 data
  bit e_mreq, e_iaok, e_daok, e_iok, e_dok, e_pend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_eval();
    bit spri;
    spri = (m_starve >= int'(LIMIT)) && bus_if.inst_req;
    if (m_lock_v)                        win = m_lock_d ? (bus_if.data_req ? 2 : 0) : (bus_if.inst_req ? 1 : 0);
    else if (bus_if.data_req && !spri)   win = 2;
    else if (bus_if.inst_req)            win = 1;
    else                                 win = 0;
    e_mreq = (win != 0) && (mq.size() < int'(DEPTH)) && !reset;
    e_iaok = e_mreq && bus_if.mem_addr_ok && (win == 1);
    e_daok = e_mreq && bus_if.mem_addr_ok && (win == 2);
    e_iok  = 1'b0;
    e_dok  = 1'b0;
    if (!reset && bus_if.mem_data_ok && mq.size() > 0) begin
      e_dok = mq[0].own_d;
      e_iok = !mq[0].own_d && !mq[0].disc && !bus_if.inst_cancel;
    end
    e_pend = 1'b0;
    foreach (mq[k]) if (!mq[k].own_d && !mq[k].disc) e_pend = 1'b1;
  endfunction

  task automatic compare_model();
    chk("mem_req",      32'(bus_if.mem_req),      32'(e_mreq));
    chk("inst_addr_ok", 32'(bus_if.inst_addr_ok), 32'(e_iaok));
    chk("data_addr_ok", 32'(bus_if.data_addr_ok), 32'(e_daok));
    chk("inst_data_ok", 32'(bus_if.inst_data_ok), 32'(e_iok));
    chk("data_data_ok", 32'(bus_if.data_data_ok), 32'(e_dok));
    chk("inst_pending", 32'(bus_if.inst_pending), 32'(e_pend));
    if (e_mreq && win == 2) begin
      chk("mem_addr_d", bus_if.mem_addr,        bus_if.data_addr);
      chk("mem_wr_d",   32'(bus_if.mem_wr),     32'(bus_if.data_wr));
      chk("mem_size_d", 32'(bus_if.mem_size),   32'(bus_if.data_size));
      if (bus_if.data_wr) chk("mem_wdata", bus_if.mem_wdata, bus_if.data_wdata);
    end
    if (e_mreq && win == 1) begin
      chk("mem_addr_i", bus_if.mem_addr,      bus_if.inst_addr);
      chk("mem_wr_i",   32'(bus_if.mem_wr),   32'd0);
      chk("mem_size_i", 32'(bus_if.mem_size), 32'd2);
    end
    if (e_iok) chk("inst_rdata", bus_if.inst_rdata, bus_if.mem_rdata);
    if (e_dok) chk("data_rdata", bus_if.data_rdata, bus_if.mem_rdata);
  endtask

  function automatic void model_update();
    bit   acc;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_lock_v = 1'b0;
      m_starve = 0;
      return;
    end
    acc = e_mreq && bus_if.mem_addr_ok;
    if (e_mreq && !bus_if.mem_addr_ok) begin
      m_lock_v = 1'b1;
      m_lock_d = (win == 2);
    end
    if (acc) m_lock_v = 1'b0;
    if (e_iaok) m_starve = 0;
    else if (acc && win == 2 && bus_if.inst_req) m_starve = (m_starve < int'(LIMIT)) ? m_starve + 1 : int'(LIMIT);
    if (bus_if.mem_data_ok && mq.size() > 0) void'(mq.pop_front());
    if (bus_if.inst_cancel) foreach (mq[k]) if (!mq[k].own_d) mq[k].disc = 1'b1;
    if (acc) begin
      e.own_d = (win == 2);
      e.disc  = 1'b0;
      mq.push_back(e);
    end
  endfunction

  task automatic cyc_check();
    #1;
    model_eval();
    compare_model();
  endtask

  task automatic cyc_end();
    @(posedge clk);
    model_update();
  endtask

  task automatic idle();
    bus_if.inst_req    = 1'b0;
    bus_if.inst_cancel = 1'b0;
    bus_if.data_req    = 1'b0;
    bus_if.mem_addr_ok = 1'b0;
    bus_if.mem_data_ok = 1'b0;
  endtask

  // Plain cycle with current inputs, model checks only
  task automatic run_cycle();
    @(negedge clk);
    cyc_check();
    cyc_end();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  ndok;
    int  won_at;
    bit  ihold, dhold;

    reset = 1'b1;
    idle();
    bus_if.inst_addr  = '0;
    bus_if.data_wr    = 1'b0;
    bus_if.data_size  = 2'd2;
    bus_if.data_addr  = '0;
    bus_if.data_wdata = '0;
    bus_if.mem_rdata  = '0;
    m_lock_v = 1'b0;
    m_lock_d = 1'b0;
    m_starve = 0;

    // Reset state
    repeat (2) begin
      @(negedge clk);
      bus_if.inst_req = 1'b1;
      cyc_check();
      chk("rst_mem_req", 32'(bus_if.mem_req), 32'd0);
      cyc_end();
    end
    @(negedge clk);
    reset = 1'b0;
    idle();
    cyc_check();
    chk("rst_pending", 32'(bus_if.inst_pending), 32'd0);
    cyc_end();

    // T1 lone inst read
    @(negedge clk);
    bus_if.inst_req = 1'b1; bus_if.inst_addr = 32'hBFC0_0000; bus_if.mem_addr_ok = 1'b1;
    cyc_check();
    chk("t1_mem_size", 32'(bus_if.mem_size), 32'd2);
    chk("t1_iaok", 32'(bus_if.inst_addr_ok), 32'd1);
    cyc_end();
    @(negedge clk); idle(); cyc_check(); cyc_end();
    @(negedge clk);
    bus_if.mem_data_ok = 1'b1; bus_if.mem_rdata = 32'h2401_0001;
    cyc_check();
    chk("t1_iok", 32'(bus_if.inst_data_ok), 32'd1);
    chk("t1_rdata", bus_if.inst_rdata, 32'h2401_0001);
    cyc_end();

    // T2 conflict: data first, inst next, responses in order
    @(negedge clk);
    idle();
    bus_if.inst_req = 1'b1; bus_if.inst_addr = 32'hBFC0_0004;
    bus_if.data_req = 1'b1; bus_if.data_wr = 1'b1; bus_if.data_size = 2'd2;
    bus_if.data_addr = 32'h0000_1000; bus_if.data_wdata = 32'hDEAD_BEEF;
    bus_if.mem_addr_ok = 1'b1;
    cyc_check();
    chk("t2_daok", 32'(bus_if.data_addr_ok), 32'd1);
    chk("t2_iaok0", 32'(bus_if.inst_addr_ok), 32'd0);
    chk("t2_addr", bus_if.mem_addr, 32'h0000_1000);
    cyc_end();
    @(negedge clk);
    bus_if.data_req = 1'b0;
    cyc_check();
    chk("t2_iaok", 32'(bus_if.inst_addr_ok), 32'd1);
    cyc_end();
    @(negedge clk);
    idle(); bus_if.mem_data_ok = 1'b1; bus_if.mem_rdata = 32'h0;
    cyc_check();
    chk("t2_dok_first", 32'(bus_if.data_data_ok), 32'd1);
    chk("t2_iok_first", 32'(bus_if.inst_data_ok), 32'd0);
    cyc_end();
    @(negedge clk);
    bus_if.mem_rdata = 32'h1234_5678;
    cyc_check();
    chk("t2_iok_second", 32'(bus_if.inst_data_ok), 32'd1);
    cyc_end();

    // T3 lock: inst stalled three cycles, data arrives meanwhile
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle();
      bus_if.inst_req = 1'b1; bus_if.inst_addr = 32'hBFC0_0010;
      bus_if.data_req = (c >= 1); bus_if.data_wr = 1'b0; bus_if.data_addr = 32'h0000_2000;
      cyc_check();
      chk("t3_addr_held", bus_if.mem_addr, 32'hBFC0_0010);
      chk("t3_no_daok", 32'(bus_if.data_addr_ok), 32'd0);
      cyc_end();
    end
    @(negedge clk);
    bus_if.mem_addr_ok = 1'b1;
    cyc_check();
    chk("t3_iaok", 32'(bus_if.inst_addr_ok), 32'd1);
    cyc_end();
    @(negedge clk);
    bus_if.inst_req = 1'b0;
    cyc_check();
    chk("t3_daok_after", 32'(bus_if.data_addr_ok), 32'd1);
    cyc_end();
    @(negedge clk); idle(); bus_if.mem_data_ok = 1'b1; cyc_check(); cyc_end();
    @(negedge clk); cyc_check(); cyc_end();

    // T4 full FIFO blocks the fifth request until a response retires
    @(negedge clk); idle(); cyc_check(); cyc_end();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus_if.data_req = 1'b1; bus_if.data_wr = 1'b0; bus_if.data_addr = 32'h0000_3000 + 32'(4 * c);
      bus_if.mem_addr_ok = 1'b1;
      cyc_check();
      chk("t4_fill", 32'(bus_if.data_addr_ok), 32'd1);
      cyc_end();
    end
    @(negedge clk);
    cyc_check();
    chk("t4_full_block", 32'(bus_if.mem_req), 32'd0);
    cyc_end();
    @(negedge clk);
    bus_if.mem_data_ok = 1'b1;
    cyc_check();
    chk("t4_full_pop_block", 32'(bus_if.mem_req), 32'd0);
    cyc_end();
    @(negedge clk);
    bus_if.mem_data_ok = 1'b0;
    cyc_check();
    chk("t4_fifth_accept", 32'(bus_if.data_addr_ok), 32'd1);
    cyc_end();
    @(negedge clk); idle(); bus_if.mem_data_ok = 1'b1;
    cyc_check(); cyc_end();
    repeat (3) run_cycle();

    // T5 cancel: two inst reads and one data read in flight
    @(negedge clk); idle(); cyc_check(); cyc_end();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle();
      bus_if.mem_addr_ok = 1'b1;
      if (c < 2) begin bus_if.inst_req = 1'b1; bus_if.inst_addr = 32'hBFC0_0100 + 32'(4 * c); end
      else begin bus_if.data_req = 1'b1; bus_if.data_wr = 1'b0; bus_if.data_addr = 32'h0000_4000; end
      cyc_check();
      cyc_end();
    end
    @(negedge clk);
    idle(); bus_if.inst_cancel = 1'b1;
    cyc_check();
    chk("t5_pending_before", 32'(bus_if.inst_pending), 32'd1);
    cyc_end();
    ndok = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle(); bus_if.mem_data_ok = 1'b1;
      cyc_check();
      chk("t5_pending_after", 32'(bus_if.inst_pending), 32'd0);
      chk("t5_no_iok", 32'(bus_if.inst_data_ok), 32'd0);
      ndok += int'(bus_if.data_data_ok);
      cyc_end();
    end
    chk("t5_dok_count", 32'(ndok), 32'd1);

    // T6 starvation: inst wins the ninth arbitration
    @(negedge clk); idle(); cyc_check(); cyc_end();
    won_at = 0;
    for (int c = 1; c <= 20 && won_at == 0; c++) begin
      @(negedge clk);
      bus_if.inst_req = 1'b1; bus_if.inst_addr = 32'hBFC0_0200;
      bus_if.data_req = 1'b1; bus_if.data_wr = 1'b0; bus_if.data_addr = 32'h0000_5000;
      bus_if.mem_addr_ok = 1'b1;
      bus_if.mem_data_ok = (mq.size() > 0);
      cyc_check();
      if (bus_if.inst_addr_ok) won_at = c;
      cyc_end();
    end
    chk("t6_win_at", 32'(won_at), 32'd9);
    @(negedge clk);
    bus_if.mem_data_ok = (mq.size() > 0);
    cyc_check();
    chk("t6_starve_cleared", 32'(bus_if.data_addr_ok), 32'd1);
    cyc_end();
    @(negedge clk);
    bus_if.mem_data_ok = 1'b0;
    cyc_check(); cyc_end();
    @(negedge clk);
    reset = 1'b1; bus_if.mem_data_ok = 1'b1;
    cyc_check();
    chk("t6_rst_mem_req", 32'(bus_if.mem_req), 32'd0);
    chk("t6_rst_aok", 32'(bus_if.data_addr_ok | bus_if.inst_addr_ok), 32'd0);
    chk("t6_rst_dok", 32'(bus_if.data_data_ok | bus_if.inst_data_ok), 32'd0);
    cyc_end();
    @(negedge clk);
    reset = 1'b0; idle();
    cyc_check();
    chk("t6_rst_empty", 32'(bus_if.inst_pending), 32'd0);
    cyc_end();

    // Random traffic with held requests, random stalls, cancels and resets
    ihold = 1'b0;
    dhold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!ihold && $urandom_range(0, 2) == 0) begin
        ihold = 1'b1;
        bus_if.inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dhold && $urandom_range(0, 2) == 0) begin
        dhold = 1'b1;
        bus_if.data_wr    = 1'($urandom_range(0, 1));
        bus_if.data_size  = 2'($urandom_range(0, 2));
        bus_if.data_addr  = $urandom;
        bus_if.data_wdata = $urandom;
      end
      reset              = ($urandom_range(0, 299) == 0);
      bus_if.inst_req    = ihold;
      bus_if.data_req    = dhold;
      bus_if.mem_addr_ok = ($urandom_range(0, 3) != 0);
      bus_if.mem_data_ok = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
      bus_if.mem_rdata   = $urandom;
      bus_if.inst_cancel = ($urandom_range(0, 19) == 0);
      cyc_check();
      if (e_iaok) ihold = 1'b0;
      if (e_daok) dhold = 1'b0;
      cyc_end();
    end
    @(negedge clk);
    reset = 1'b0;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
